// File: rtl/homography_arbiter.sv
// Round-robin arbiter sharing one homography lookup engine between two pixel
// requesters. It keeps one engine transaction in flight, checks the echoed coordinate, and abandons a silent engine after a timeout.
module homography_arbiter #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        req0_start,
    input  logic [9:0]  req0_x,
    input  logic [9:0]  req0_y,
    output logic        req0_busy,
    output logic        req0_ready,
    output logic        req0_timeout,
    input  logic        req1_start,
    input  logic [9:0]  req1_x,
    input  logic [9:0]  req1_y,
    output logic        req1_busy,
    output logic        req1_ready,
    output logic        req1_timeout,
    output logic        hom_start,
    output logic [9:0]  hom_query_x,
    output logic [9:0]  hom_query_y,
    input  logic        hom_ready,
    input  logic [9:0]  hom_return_x,
    input  logic [9:0]  hom_return_y,
    input  logic [4:0]  hom_r,
    input  logic [5:0]  hom_g,
    input  logic [4:0]  hom_b,
    output logic [9:0]  rsp_x,
    output logic [9:0]  rsp_y,
    output logic [4:0]  rsp_r,
    output logic [5:0]  rsp_g,
    output logic [4:0]  rsp_b,
    output logic        grant_id,
    output logic        mismatch
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       pending_q, pending_d;
    logic [9:0]       lat_x_q [2];
    logic [9:0]       lat_x_d [2];
    logic [9:0]       lat_y_q [2];
    logic [9:0]       lat_y_d [2];
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hom_start_q, hom_start_d;
    logic [9:0]       query_x_q, query_x_d;
    logic [9:0]       query_y_q, query_y_d;
    logic [1:0]       ready_q, ready_d;
    logic [1:0]       timeout_q, timeout_d;
    logic             mismatch_q, mismatch_d;
    logic [9:0]       rsp_x_q, rsp_x_d;
    logic [9:0]       rsp_y_q, rsp_y_d;
    logic [4:0]       rsp_r_q, rsp_r_d;
    logic [5:0]       rsp_g_q, rsp_g_d;
    logic [4:0]       rsp_b_q, rsp_b_d;

    logic [1:0]       req_start;
    logic [9:0]       req_x [2];
    logic [9:0]       req_y [2];
    logic             winner;

    assign req_start = {req1_start, req0_start};
    assign req_x[0]  = req0_x;
    assign req_x[1]  = req1_x;
    assign req_y[0]  = req0_y;
    assign req_y[1]  = req1_y;

    // On a tie the requester that did not win last time goes next.
    assign winner = (&pending_q) ? ~last_grant_q : pending_q[1];

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d      = state_q;
        pending_d    = pending_q;
        lat_x_d      = lat_x_q;
        lat_y_d      = lat_y_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        query_x_d    = query_x_q;
        query_y_d    = query_y_q;
        rsp_x_d      = rsp_x_q;
        rsp_y_d      = rsp_y_q;
        rsp_r_d      = rsp_r_q;
        rsp_g_d      = rsp_g_q;
        rsp_b_d      = rsp_b_q;
        hom_start_d  = 1'b0;
        ready_d      = 2'b00;
        timeout_d    = 2'b00;
        mismatch_d   = 1'b0;

        for (int i = 0; i < 2; i++) begin
            if (req_start[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                lat_x_d[i]   = req_x[i];
                lat_y_d[i]   = req_y[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    query_x_d    = lat_x_q[winner];
                    query_y_d    = lat_y_q[winner];
                    hom_start_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the last allowed cycle still counts as a completion.
                if (hom_ready) begin
                    rsp_x_d            = hom_return_x;
                    rsp_y_d            = hom_return_y;
                    rsp_r_d            = hom_r;
                    rsp_g_d            = hom_g;
                    rsp_b_d            = hom_b;
                    ready_d[grant_q]   = 1'b1;
                    mismatch_d         = {hom_return_x, hom_return_y} != {query_x_q, query_y_q};
                    pending_d[grant_q] = 1'b0;
                    state_d            = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d[grant_q] = 1'b1;
                    pending_d[grant_q] = 1'b0;
                    state_d            = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= 2'b00;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            hom_start_q  <= 1'b0;
            query_x_q    <= '0;
            query_y_q    <= '0;
            ready_q      <= 2'b00;
            timeout_q    <= 2'b00;
            mismatch_q   <= 1'b0;
            rsp_x_q      <= '0;
            rsp_y_q      <= '0;
            rsp_r_q      <= '0;
            rsp_g_q      <= '0;
            rsp_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            hom_start_q  <= hom_start_d;
            query_x_q    <= query_x_d;
            query_y_q    <= query_y_d;
            ready_q      <= ready_d;
            timeout_q    <= timeout_d;
            mismatch_q   <= mismatch_d;
            rsp_x_q      <= rsp_x_d;
            rsp_y_q      <= rsp_y_d;
            rsp_r_q      <= rsp_r_d;
            rsp_g_q      <= rsp_g_d;
            rsp_b_q      <= rsp_b_d;
        end
    end

    // NOTE: latched query coordinates are not reset; they are only read while their pending bit is set.
    always_ff @(posedge clk_25) begin
        lat_x_q <= lat_x_d;
        lat_y_q <= lat_y_d;
    end

    assign req0_busy    = pending_q[0];
    assign req1_busy    = pending_q[1];
    assign req0_ready   = ready_q[0];
    assign req1_ready   = ready_q[1];
    assign req0_timeout = timeout_q[0];
    assign req1_timeout = timeout_q[1];
    assign hom_start    = hom_start_q;
    assign hom_query_x  = query_x_q;
    assign hom_query_y  = query_y_q;
    assign rsp_x        = rsp_x_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_r        = rsp_r_q;
    assign rsp_g        = rsp_g_q;
    assign rsp_b        = rsp_b_q;
    assign grant_id     = grant_q;
    assign mismatch     = mismatch_q;

endmodule

// File: doc/homography_arbiter.md
# homography_arbiter

Shares one homography lookup engine between two independent pixel requesters, e.g. two sync_controller-style streams or a display stream plus a calibration stream. Each requester posts a query coordinate and gets back the engine's returned coordinate and RGB565 pixel. The arbiter serves the requesters round-robin with one outstanding engine transaction at a time. It checks each returned coordinate against the issued query and abandons a transaction that receives no response within a timeout.

## Interface
Parameters:
- TIMEOUT, 1023: number of WAIT cycles without hom_ready before a transaction is abandoned. Legal range 2..1023.
- CNT_W, 10: width of the timeout counter.

Ports:
- clk_25  in  1  system clock. One clock domain.
- rst  in  1  reset, synchronous, active-high.
- req0_start  in  1  single-cycle request strobe from requester 0.
- req0_x / req0_y  in  10 each  query coordinate, sampled with req0_start.
- req0_busy  out  1  requester 0 has a pending or in-flight query.
- req0_ready  out  1  one-cycle completion pulse. rsp_* are valid in the same cycle.
- req0_timeout  out  1  one-cycle abandon pulse.
- req1_start, req1_x, req1_y, req1_busy, req1_ready, req1_timeout: same as requester 0, for requester 1.
- hom_start  out  1  one-cycle engine launch strobe.
- hom_query_x / hom_query_y  out  10 each  coordinate issued to the engine. Held stable until the next launch.
- hom_ready  in  1  engine completion strobe.
- hom_return_x / hom_return_y  in  10 each  coordinate echoed by the engine.
- hom_r  in  5, hom_g  in  6, hom_b  in  5  engine pixel.
- rsp_x / rsp_y  out  10 each  captured return coordinate.
- rsp_r  out  5, rsp_g  out  6, rsp_b  out  5  captured pixel.
- grant_id  out  1  requester owning the current or last transaction.
- mismatch  out  1  pulses together with reqN_ready when the returned coordinate differs from the issued query.

## Operation
- Pending registers:
  - reqN_start while reqN_busy=0 latches reqN_x/reqN_y and sets pendingN.
  - reqN_start while busy=1 is ignored.
  - reqN_busy = pendingN. It stays high through issue and wait and clears at the completion or timeout edge.
- Round-robin pointer last_grant, reset value 1:
  - If both requesters are pending, the one not equal to last_grant wins.
  - If only one is pending, it wins.
  - last_grant updates to the winner at launch.
- FSM S_IDLE → S_WAIT → S_IDLE.
  - S_IDLE: if any pendingN is set (registered value), the arbiter:
    - selects the winner;
    - loads hom_query_x/y from the winner's latched coordinate;
    - sets grant_id;
    - pulses hom_start;
    - clears the timeout counter;
    - goes to S_WAIT.
  - S_WAIT, hom_ready=1: the arbiter:
    - captures hom_return_x/y into rsp_x/y and hom_r/g/b into rsp_r/g/b;
    - pulses req[grant_id]_ready;
    - pulses mismatch if {hom_return_x, hom_return_y} ≠ {hom_query_x, hom_query_y};
    - clears pending[grant_id];
    - goes to S_IDLE.
  - S_WAIT, no hom_ready: the counter increments. When counter = TIMEOUT-1, the arbiter pulses req[grant_id]_timeout, clears pending[grant_id], leaves rsp_* unchanged and goes to S_IDLE.
  - hom_ready and the timeout condition in the same cycle: hom_ready wins, with no timeout pulse.
- hom_ready in S_IDLE is ignored, including a late response after a timeout.
- The counter saturates and never wraps, because TIMEOUT ≤ 2^CNT_W − 1.
- rst mid-transaction: the arbiter returns to S_IDLE and clears all pending state. Any engine response arriving later is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - All outputs 0: busy, ready, timeout, hom_start, mismatch, hom_query_*, rsp_*, grant_id.
  - state=S_IDLE, counter=0, last_grant=1.
- Latency:
  - reqN_start in cycle t: busy high from t+1.
  - hom_start high in cycle t+2 if the engine is idle.
  - hom_ready in cycle u: reqN_ready, rsp_* and mismatch valid in u+1. busy low in u+1.
- Back-to-back: the next hom_start comes no earlier than u+2.
- A requester may restart in the cycle its busy falls. That start is accepted because busy is sampled low.
- Pulses (ready, timeout, hom_start, mismatch) are exactly one cycle wide.

## Test plan
- Single request: req0_start with (100,200); engine returns (100,200), RGB (5'h1F,6'h00,5'h0A) after 4 cycles. Required: hom_start at t+2; req0_ready one cycle after hom_ready with rsp=(100,200,1F,00,0A); mismatch=0; req0_busy falls on the same edge.
- Contention: req0_start and req1_start in the same cycle. Required: requester 0 served first (last_grant=1 after reset), then requester 1. Repeating both strobes gives order 0,1,0,1; grant_id tracks each transaction.
- Mismatch: query (10,20), engine returns (10,21). Required: req0_ready=1 and mismatch=1 in the same cycle; rsp_y=21.
- Timeout with TIMEOUT=8: engine never responds. Required: req1_timeout exactly 8 cycles after hom_start; busy clears; a hom_ready arriving 3 cycles later produces no ready pulse.
- Ignored start and boundary tie: req0_start while req0_busy=1 does not change hom_query_x. hom_ready on the same cycle the counter hits TIMEOUT-1 produces ready, not timeout.
- Reset mid-wait: assert rst for 1 cycle in S_WAIT. Required: all outputs 0 the next cycle; a following hom_ready is ignored; a new request is served normally.
